present_key_sched_ctrl: RTL
===========================

Name: present_key_sched_ctrl

Overview:
- Sequencing controller for the PRESENT-80 key schedule.
- Accepts an 80-bit master key through a valid/ready load handshake and keeps a copy for replay.
- Steps the key register through 31 update rounds and streams the 32 round keys, one per handshake, to the cipher round datapath.
- Sits between the key source and the encryption round loop; owns the round counter so the datapath never tracks round numbers.

Parameters:
- ROUNDS, 31: number of key-register updates; round keys emitted = ROUNDS+1; legal range 1..31.
- CNT_W, 5: round-counter width XORed into key bits [19:15]; fixed at 5 for PRESENT.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-low (rst==0 resets on the clock edge).
- key_in  input  80  master key, bit 79 MSB.
- key_valid  input  1  key_in valid.
- key_ready  output  1  controller can accept a key.
- restart  input  1  one-cycle pulse: re-run the schedule from the stored key.
- abort  input  1  one-cycle pulse: drop the current schedule and return to IDLE.
- rk_out  output  64  current round key = key_reg[79:16].
- rk_round  output  6  index of rk_out, 1..ROUNDS+1.
- rk_valid  output  1  rk_out/rk_round valid.
- rk_ready  input  1  consumer accepts the round key.
- rk_last  output  1  rk_valid && rk_round==ROUNDS+1.
- busy  output  1  state==EMIT.

Behaviour:
- Reset values:
  - state=IDLE, key_reg=0, saved_key=0, key_loaded=0.
  - rk_round=0, rk_valid=0, rk_last=0, busy=0.
  - key_ready=1 starting the first cycle after reset is released.
- States: IDLE and EMIT. key_ready=(state==IDLE). rk_valid=busy=(state==EMIT).
- IDLE:
  - On key_valid&&key_ready: key_reg<=key_in, saved_key<=key_in, key_loaded<=1, rk_round<=1, go to EMIT.
  - rk_valid rises in the next cycle (1-cycle latency).
- IDLE with restart && key_loaded && !key_valid: key_reg<=saved_key, rk_round<=1, go to EMIT.
- IDLE with restart && !key_loaded: ignored. key_valid takes priority over restart.
- EMIT: rk_out, rk_round and rk_last stay stable while rk_ready=0. Unlimited backpressure; no timeout.
- EMIT handshake (rk_valid&&rk_ready) with rk_round<=ROUNDS: apply the update using counter i=rk_round[4:0], all from the current key_reg:
  - Rotate left by 61 bits.
  - Bits [79:76] := SBox(rotated nibble [79:76]).
  - Bits [19:15] := rotated bits [19:15] XOR i.
  - rk_round<=rk_round+1.
  - Result: back-to-back throughput of one key per cycle.
- EMIT handshake with rk_round==ROUNDS+1: go to IDLE, rk_round<=0. key_reg keeps its last value.
- SBox (PRESENT): 0..F → C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2.
- abort in EMIT: go to IDLE the next cycle, rk_valid<=0, and do not update key_reg. An rk handshake in the same cycle is treated as not accepted. key_loaded is unchanged.
- Simultaneous abort and restart: abort wins. restart during EMIT is ignored.
- key_valid during EMIT: not accepted (key_ready=0); the source holds it.
- Reset mid-operation: everything returns to the reset values, including key_loaded=0, so restart is ignored until a new key is loaded.

Test Plan:
- Load key_in=0, rk_ready=1 constantly:
  - rk_round 1 gives rk_out=0x0000000000000000.
  - rk_round 2 gives rk_out=0xC000000000000000.
  - rk_round 32 gives 0x6DAB31744F41D700 with rk_last=1.
  - 32 consecutive valid cycles, then key_ready=1.
- Load key_in=80'hFFFF_FFFF_FFFF_FFFF_FFFF with random rk_ready stalls:
  - Sequence matches the software PRESENT-80 model.
  - rk_out/rk_round stay stable across stall cycles; round 32 gives 0x6E2E7A1BD6B5D1DC... (taken from the golden model output file).
- After a completed zero-key run, pulse restart without key_valid: the identical 32-key sequence replays. After reset, pulse restart: no rk_valid for 10 cycles.
- Pulse abort at rk_round=7 in the same cycle as rk_ready=1:
  - Next cycle rk_valid=0 and key_ready=1.
  - A following restart begins again at rk_round=1 with rk_out=0.
- Drive rst=0 for one cycle at rk_round=15: the next cycle shows rk_valid=0, rk_round=0, key_ready=1, and a subsequent restart is ignored.
- Pulse key_valid and restart together in IDLE: the new key_in is used, confirmed by its round-1 key equal to key_in[79:16].

Source files
------------

// File: rtl/present_key_sched_ctrl.sv
// -----------------------------------------------------------------------------
// present_key_sched_ctrl
//
// Sequencing controller for the PRESENT-80 key schedule. It accepts an 80-bit
// master key over a valid/ready handshake and keeps a copy so the schedule can
// be replayed. It then steps the key register through ROUNDS updates and
// streams the ROUNDS+1 round keys, one per handshake, to the cipher round
// datapath. The round counter lives here, so the datapath never tracks round
// numbers.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous reset, active-low
//   key_in     80-bit master key (bit 79 is the MSB)
//   key_valid  key_in is valid
//   key_ready  controller can accept a key (idle)
//   restart    one-cycle pulse: re-run the schedule from the stored key
//   abort      one-cycle pulse: drop the current schedule and go idle
//   rk_out     current round key, key_reg[79:16]
//   rk_round   index of rk_out, 1..ROUNDS+1 (0 when idle)
//   rk_valid   rk_out/rk_round valid
//   rk_ready   consumer accepts the round key
//   rk_last    rk_valid && rk_round == ROUNDS+1
//   busy       schedule in progress
// -----------------------------------------------------------------------------
module present_key_sched_ctrl #(
  parameter int ROUNDS = 31,  // key-register updates; legal range 1..31
  parameter int CNT_W  = 5    // round-counter width XORed into key[19:15]
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [79:0] key_in,
  input  logic        key_valid,
  output logic        key_ready,
  input  logic        restart,
  input  logic        abort,
  output logic [63:0] rk_out,
  output logic [5:0]  rk_round,
  output logic        rk_valid,
  input  logic        rk_ready,
  output logic        rk_last,
  output logic        busy
);

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  localparam logic [5:0] LAST_ROUND = 6'(ROUNDS + 1);

  state_t      state_q, state_d;
  logic [79:0] key_q, key_d;
  logic [79:0] saved_q, saved_d;
  logic        loaded_q, loaded_d;
  logic [5:0]  round_q, round_d;

  // PRESENT 4-bit S-box.
  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hC;  4'h1: y = 4'h5;  4'h2: y = 4'h6;  4'h3: y = 4'hB;
      4'h4: y = 4'h9;  4'h5: y = 4'h0;  4'h6: y = 4'hA;  4'h7: y = 4'hD;
      4'h8: y = 4'h3;  4'h9: y = 4'hE;  4'hA: y = 4'hF;  4'hB: y = 4'h8;
      4'hC: y = 4'h4;  4'hD: y = 4'h7;  4'hE: y = 4'h1;  default: y = 4'h2;
    endcase
    return y;
  endfunction

  // One key-register update: rotate left by 61 (equivalently right by 19),
  // substitute the top nibble, then fold the round counter into bits [19:15].
  function automatic logic [79:0] key_update(input logic [79:0]      k,
                                             input logic [CNT_W-1:0] i);
    logic [79:0] r;
    r          = {k[18:0], k[79:19]};
    r[79:76]   = sbox(r[79:76]);
    r[19:15]   = r[19:15] ^ i;
    return r;
  endfunction

  // NOTE: state updates use non-blocking assignments so every register samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      key_q    <= '0;
      saved_q  <= '0;
      loaded_q <= 1'b0;
      round_q  <= '0;
    end else begin
      state_q  <= state_d;
      key_q    <= key_d;
      saved_q  <= saved_d;
      loaded_q <= loaded_d;
      round_q  <= round_d;
    end
  end

  // NOTE: every signal driven here gets a hold-value default first, so no path
  // through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    key_d    = key_q;
    saved_d  = saved_q;
    loaded_d = loaded_q;
    round_d  = round_q;

    unique case (state_q)
      IDLE: begin
        // A fresh key wins over a replay request in the same cycle.
        if (key_valid) begin
          key_d    = key_in;
          saved_d  = key_in;
          loaded_d = 1'b1;
          round_d  = 6'd1;
          state_d  = EMIT;
        end else if (restart && loaded_q) begin
          key_d    = saved_q;
          round_d  = 6'd1;
          state_d  = EMIT;
        end
      end

      EMIT: begin
        // abort discards any handshake in the same cycle; restart and
        // key_valid are not acted on while emitting.
        if (abort) begin
          state_d = IDLE;
          round_d = '0;
        end else if (rk_ready) begin
          if (round_q == LAST_ROUND) begin
            // Final key consumed; key_reg keeps its last value.
            state_d = IDLE;
            round_d = '0;
          end else begin
            key_d   = key_update(key_q, round_q[CNT_W-1:0]);
            round_d = round_q + 6'd1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign key_ready = (state_q == IDLE);
  assign busy      = (state_q == EMIT);
  assign rk_valid  = busy;
  assign rk_out    = key_q[79:16];
  assign rk_round  = round_q;
  assign rk_last   = rk_valid && (round_q == LAST_ROUND);

endmodule
